// File: rtl/axis_rd_checker.sv
// AXI-Stream sink that checks an incrementing per-lane pattern, counts mismatches and
// active cycles, and can throttle the source with LFSR-driven backpressure.
module axis_rd_checker #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    input  logic                  START_REG,
    input  logic [31:0]           LENGTH_REG,
    input  logic [31:0]           SEED_REG,
    input  logic                  STALL_EN_REG,
    output logic                  IDLE_REG,
    output logic                  DONE_REG,
    output logic [31:0]           BEATS_REG,
    output logic [31:0]           ERR_CNT_REG,
    output logic [31:0]           FIRST_ERR_REG,
    output logic [31:0]           CYCLES_REG
);
    localparam int          LANES     = DATA_WIDTH / 32;
    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        idle_q;
    logic [31:0] length_q;
    logic        stall_q;
    logic [15:0] lfsr;
    logic [31:0] base_q;
    logic [31:0] beats_q;
    logic [31:0] cycles_q;
    logic [31:0] err_q;
    logic [31:0] first_q;
    logic        accept;
    logic        last_beat;
    logic        start_run;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [31:0]           base_p1;
    logic [31:0]           idx_p1;
    logic                  mismatch_p1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == ALL_ONES) ? v : v + 32'd1;
    endfunction

    // Fibonacci, taps 16,14,13,11 in right-shift form; bit 0 gates tready.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign last_beat = accept && (beats_q == length_q - 32'd1);
    assign start_run = (state == S_IDLE) && START_REG;

    // FSM state register plus run-control registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            idle_q   <= 1'b0;
            length_q <= '0;
            stall_q  <= 1'b0;
            lfsr     <= LFSR_INIT;
            base_q   <= '0;
            beats_q  <= '0;
            cycles_q <= '0;
            vld_p1   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idle_q <= (state_nxt == S_IDLE);
            vld_p1 <= accept;
            if (start_run) begin
                length_q <= LENGTH_REG;
                stall_q  <= STALL_EN_REG;
                base_q   <= SEED_REG;
                lfsr     <= LFSR_INIT;
                beats_q  <= '0;
                cycles_q <= '0;
            end else if (state == S_RUN) begin
                lfsr <= lfsr_step(lfsr);
                if (accept) begin
                    beats_q <= sat_inc(beats_q);
                    base_q  <= base_q + 32'(LANES);
                end
                if (accept && (beats_q == '0))
                    cycles_q <= 32'd1;
                else if (beats_q != '0)
                    cycles_q <= sat_inc(cycles_q);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START_REG) state_nxt = (LENGTH_REG == '0) ? S_FLUSH : S_RUN;
            S_RUN:   if (last_beat) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  if (!START_REG) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = (state == S_RUN) && (!stall_q || lfsr[0]);
        DONE_REG      = (state == S_DONE);
        IDLE_REG      = idle_q;
    end

    // stage 1: capture accepted beat with its expected lane-0 value and index
    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1 <= s_axis_tdata;
            base_p1 <= base_q;
            idx_p1  <= beats_q;
        end
    end

    always_comb begin
        mismatch_p1 = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (data_p1[32*i +: 32] != base_p1 + 32'(i))
                mismatch_p1 = 1'b1;
        end
    end

    // stage 2: error accounting
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q   <= '0;
            first_q <= ALL_ONES;
        end else if (start_run) begin
            err_q   <= '0;
            first_q <= ALL_ONES;
        end else if (vld_p1 && mismatch_p1) begin
            err_q <= sat_inc(err_q);
            if (first_q == ALL_ONES)
                first_q <= idx_p1;
        end
    end

    assign BEATS_REG     = beats_q;
    assign ERR_CNT_REG   = err_q;
    assign FIRST_ERR_REG = first_q;
    assign CYCLES_REG    = cycles_q;

endmodule
